// File: rtl/event_readout_arbiter.sv
// event_readout_arbiter
//   Scheduler in front of the event readout datamover (memclk domain).
//   Arbitrates the compressed completion stream (full-event readouts, gated by
//   allow_i credits) against the nack stream (re-reads, normally higher priority).
//   Only one readout request is outstanding at a time. A new request is not loaded
//   until done_i returns from the readout side.
//
//   Ports
//     memclk, aresetn           clock, synchronous active-low reset
//     s_cmpl_*                  completion stream: [11:0] upper addr, [12] error
//     s_nack_*                  nack stream: [18:0] byte offset, [31:20] upper addr,
//                               [42:32] qwords, [46] full-event
//     allow_i                   +1 credit pulse
//     m_req_*                   request: [18:0] lower addr, [37:19] btt, [49:38] upper,
//                               [50] nack, [51] error
//     done_i                    readout of the outstanding request finished
//     credit_o, busy_o, overflow_o  status (overflow_o is sticky)
//     nack_grants_o, cmpl_grants_o, drop_count_o  statistics
//
//   Optional feature macro: ARB_STATS_EN. When it is defined, the statistics
//   counters are built. When it is not defined, the statistics outputs are tied to 0.
module event_readout_arbiter #(
  parameter logic [18:0] START_OFFSET = 19'h03F00,
  parameter logic [18:0] BTT          = 19'd459008,
  parameter int unsigned CREDIT_W     = 13,
  parameter int unsigned MAX_NACK_RUN = 4
) (
  input  logic                memclk,
  input  logic                aresetn,
  input  logic [15:0]         s_cmpl_tdata,
  input  logic                s_cmpl_tvalid,
  output logic                s_cmpl_tready,
  input  logic [47:0]         s_nack_tdata,
  input  logic                s_nack_tvalid,
  output logic                s_nack_tready,
  input  logic                allow_i,
  output logic [51:0]         m_req_tdata,
  output logic                m_req_tvalid,
  input  logic                m_req_tready,
  input  logic                done_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic [15:0]         nack_grants_o,
  output logic [15:0]         cmpl_grants_o,
  output logic [7:0]          drop_count_o
);

  localparam int unsigned          RUN_W   = $clog2(MAX_NACK_RUN + 2);
  localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(MAX_NACK_RUN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [51:0]         req_q;
  logic                req_is_nack;
  logic [RUN_W-1:0]    run_cnt;
  logic [CREDIT_W-1:0] credit;
  logic                overflow;

  logic                load_cmpl, load_nack, drop_nack, hs;
  logic                cmpl_elig, nack_full, nack_zero;
  logic [10:0]         nack_qw;
  logic [18:0]         nack_lower, nack_btt;
  logic [51:0]         cmpl_word, nack_word;
  logic                cmpl_dec;

  assign nack_full  = s_nack_tdata[46];
  assign nack_qw    = s_nack_tdata[42:32];
  assign nack_zero  = !nack_full && (nack_qw == '0);
  assign cmpl_elig  = s_cmpl_tvalid && (credit != '0);
  assign nack_lower = s_nack_tdata[18:0] + START_OFFSET;
  assign nack_btt   = {5'b0, nack_qw, 3'b000};

  assign cmpl_word = {s_cmpl_tdata[12], 1'b0, s_cmpl_tdata[11:0], BTT, START_OFFSET};
  assign nack_word = {1'b0, 1'b1, s_nack_tdata[31:20],
                      nack_full ? BTT : nack_btt,
                      nack_full ? START_OFFSET : nack_lower};

  // Source treadys are gated with aresetn. This keeps a request that is
  // discarded by reset from being acknowledged to its source.
  always_comb begin
    state_nxt     = state;
    load_cmpl     = 1'b0;
    load_nack     = 1'b0;
    drop_nack     = 1'b0;
    hs            = 1'b0;
    s_cmpl_tready = 1'b0;
    s_nack_tready = 1'b0;
    if (aresetn) begin
      case (state)
        ST_IDLE: begin
          // Anti-starvation: after MAX_NACK_RUN back-to-back nack grants,
          // a credited completion goes ahead of the nacks.
          if (run_cnt == RUN_MAX && cmpl_elig) begin
            load_cmpl = 1'b1;
          end else if (s_nack_tvalid) begin
            if (nack_zero) begin
              drop_nack     = 1'b1;
              s_nack_tready = 1'b1;
            end else begin
              load_nack = 1'b1;
            end
          end else if (cmpl_elig) begin
            load_cmpl = 1'b1;
          end
          if (load_cmpl || load_nack) state_nxt = ST_GRANT;
        end
        ST_GRANT: begin
          if (m_req_tready) begin
            hs            = 1'b1;
            s_nack_tready = req_is_nack;
            s_cmpl_tready = !req_is_nack;
            state_nxt     = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (done_i) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cmpl_dec = hs && !req_is_nack;

  always_ff @(posedge memclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      req_is_nack <= 1'b0;
      run_cnt     <= '0;
      credit      <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (load_cmpl) begin
        req_q       <= cmpl_word;
        req_is_nack <= 1'b0;
      end else if (load_nack) begin
        req_q       <= nack_word;
        req_is_nack <= 1'b1;
      end

      if (load_cmpl) begin
        run_cnt <= '0;
      end else if (hs) begin
        if (!req_is_nack)          run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
      end

      // A credit pulse in the same cycle as a cmpl grant cancels out.
      if (allow_i && !cmpl_dec) begin
        if (credit == '1) overflow <= 1'b1;
        else              credit   <= credit + 1'b1;
      end else if (!allow_i && cmpl_dec) begin
        credit <= credit - 1'b1;
      end
    end
  end

  assign m_req_tdata  = req_q;
  assign m_req_tvalid = (state == ST_GRANT);
  assign busy_o       = (state != ST_IDLE);
  assign credit_o     = credit;
  assign overflow_o   = overflow;

`ifdef ARB_STATS_EN
  logic [15:0] nack_cnt, cmpl_cnt;
  logic [7:0]  drop_cnt;

  always_ff @(posedge memclk) begin
    if (!aresetn) begin
      nack_cnt <= '0;
      cmpl_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (hs && req_is_nack)  nack_cnt <= nack_cnt + 16'd1;
      if (cmpl_dec)           cmpl_cnt <= cmpl_cnt + 16'd1;
      if (drop_nack && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign nack_grants_o = nack_cnt;
  assign cmpl_grants_o = cmpl_cnt;
  assign drop_count_o  = drop_cnt;
`else
  assign nack_grants_o = '0;
  assign cmpl_grants_o = '0;
  assign drop_count_o  = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_cmpl_tdata[15:13], s_nack_tdata[47], s_nack_tdata[45:43],
                         s_nack_tdata[19], drop_nack};

endmodule

// File: tb/tb_event_readout_arbiter.sv
// Directed testbench for event_readout_arbiter.
// Inputs are driven and outputs sampled on the falling edge of memclk.
module tb_event_readout_arbiter;

  localparam logic [18:0] START_OFFSET = 19'h03F00;
  localparam logic [18:0] BTT          = 19'd459008;
  localparam int unsigned CREDIT_W     = 13;

  logic                memclk = 1'b0;
  logic                aresetn;
  logic [15:0]         s_cmpl_tdata;
  logic                s_cmpl_tvalid;
  logic                s_cmpl_tready;
  logic [47:0]         s_nack_tdata;
  logic                s_nack_tvalid;
  logic                s_nack_tready;
  logic                allow_i;
  logic [51:0]         m_req_tdata;
  logic                m_req_tvalid;
  logic                m_req_tready;
  logic                done_i;
  logic [CREDIT_W-1:0] credit_o;
  logic                busy_o;
  logic                overflow_o;
  logic [15:0]         nack_grants_o;
  logic [15:0]         cmpl_grants_o;
  logic [7:0]          drop_count_o;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  always #5 memclk = ~memclk;

  event_readout_arbiter #(
    .START_OFFSET (START_OFFSET),
    .BTT          (BTT),
    .CREDIT_W     (CREDIT_W),
    .MAX_NACK_RUN (4)
  ) dut (
    .memclk        (memclk),
    .aresetn       (aresetn),
    .s_cmpl_tdata  (s_cmpl_tdata),
    .s_cmpl_tvalid (s_cmpl_tvalid),
    .s_cmpl_tready (s_cmpl_tready),
    .s_nack_tdata  (s_nack_tdata),
    .s_nack_tvalid (s_nack_tvalid),
    .s_nack_tready (s_nack_tready),
    .allow_i       (allow_i),
    .m_req_tdata   (m_req_tdata),
    .m_req_tvalid  (m_req_tvalid),
    .m_req_tready  (m_req_tready),
    .done_i        (done_i),
    .credit_o      (credit_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .nack_grants_o (nack_grants_o),
    .cmpl_grants_o (cmpl_grants_o),
    .drop_count_o  (drop_count_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] req_word(input logic err, input logic nack,
                                           input logic [11:0] upper, input logic [18:0] btt,
                                           input logic [18:0] lower);
    return {err, nack, upper, btt, lower};
  endfunction

  function automatic logic [47:0] nack_in(input logic full, input logic [10:0] qw,
                                          input logic [11:0] upper, input logic [18:0] off);
    return {1'b0, full, 3'b000, qw, upper, 1'b0, off};
  endfunction

  task automatic step();
    @(negedge memclk);
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_cmpl_tdata  = '0;
    s_cmpl_tvalid = 1'b0;
    s_nack_tdata  = '0;
    s_nack_tvalid = 1'b0;
    allow_i       = 1'b0;
    m_req_tready  = 1'b0;
    done_i        = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic give_credit(input int unsigned n);
    allow_i = 1'b1;
    repeat (n) step();
    allow_i = 1'b0;
  endtask

  task automatic wait_tvalid(input string tag, input int unsigned budget);
    int unsigned k = 0;
    while (!m_req_tvalid && k < budget) begin
      step();
      k++;
    end
    check_val(tag, m_req_tvalid, 1'b1);
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic       seen;
    logic       got_nack;
    logic [6:0] exp_seq;
    int unsigned ni;

    // 1: reset state, then one credited completion
    @(negedge memclk);
    do_reset();
    check_val("rst_tvalid", m_req_tvalid, 1'b0);
    check_val("rst_tdata", m_req_tdata, '0);
    check_val("rst_credit", credit_o, '0);
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_overflow", overflow_o, 1'b0);
    give_credit(3);
    check_val("t1_credit3", credit_o, 13'd3);
    s_cmpl_tdata  = 16'h0005;
    s_cmpl_tvalid = 1'b1;
    m_req_tready  = 1'b1;
    step();
    check_val("t1_tvalid", m_req_tvalid, 1'b1);
    check_val("t1_req", m_req_tdata, req_word(1'b0, 1'b0, 12'h005, BTT, START_OFFSET));
    check_val("t1_cmpl_tready", s_cmpl_tready, 1'b1);
    check_val("t1_nack_tready", s_nack_tready, 1'b0);
    step();
    s_cmpl_tvalid = 1'b0;
    m_req_tready  = 1'b0;
    #1;
    check_val("t1_cmpl_tready_off", s_cmpl_tready, 1'b0);
    check_val("t1_tvalid_off", m_req_tvalid, 1'b0);
    check_val("t1_credit2", credit_o, 13'd2);
    check_val("t1_busy_wait", busy_o, 1'b1);
    pulse_done();
    check_val("t1_idle", busy_o, 1'b0);

    // 2: completion held off without credit
    do_reset();
    s_cmpl_tdata  = 16'h11A3;
    s_cmpl_tvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_req_tvalid) seen = 1'b1;
    end
    check_val("t2_no_req", seen, 1'b0);
    give_credit(1);
    wait_tvalid("t2_wait", 5);
    check_val("t2_req", m_req_tdata, req_word(1'b1, 1'b0, 12'h1A3, BTT, START_OFFSET));
    m_req_tready = 1'b1;
    step();
    m_req_tready  = 1'b0;
    s_cmpl_tvalid = 1'b0;
    check_val("t2_credit0", credit_o, '0);
    pulse_done();

    // 3: partial nack
    do_reset();
    give_credit(2);
    s_nack_tdata  = nack_in(1'b0, 11'd16, 12'h07A, 19'h00100);
    s_nack_tvalid = 1'b1;
    wait_tvalid("t3_wait", 5);
    check_val("t3_req", m_req_tdata, req_word(1'b0, 1'b1, 12'h07A, 19'd128, 19'h04000));
    check_val("t3_no_early_tready", s_nack_tready, 1'b0);
    m_req_tready = 1'b1;
    #1;
    check_val("t3_nack_tready", s_nack_tready, 1'b1);
    check_val("t3_cmpl_tready", s_cmpl_tready, 1'b0);
    step();
    m_req_tready  = 1'b0;
    s_nack_tvalid = 1'b0;
    check_val("t3_credit", credit_o, 13'd2);
    pulse_done();

    // 4: nack run limit lets one completion through
    do_reset();
    give_credit(5);
    exp_seq = 7'b1101111;  // bit g = grant g is a nack
    ni = 0;
    s_nack_tdata  = nack_in(1'b1, 11'd0, 12'h100, 19'h0);
    s_nack_tvalid = 1'b1;
    s_cmpl_tdata  = 16'h00C4;
    s_cmpl_tvalid = 1'b1;
    for (int g = 0; g < 7; g++) begin
      wait_tvalid($sformatf("t4_wait%0d", g), 10);
      got_nack = m_req_tdata[50];
      check_val($sformatf("t4_grant%0d_src", g), got_nack, exp_seq[g]);
      if (exp_seq[g])
        check_val($sformatf("t4_grant%0d_upper", g), m_req_tdata[49:38], 12'h100 + 12'(ni));
      else
        check_val($sformatf("t4_grant%0d_upper", g), m_req_tdata[49:38], 12'h0C4);
      m_req_tready = 1'b1;
      step();
      m_req_tready = 1'b0;
      if (got_nack) begin
        ni++;
        if (ni < 6) s_nack_tdata = nack_in(1'b1, 11'd0, 12'h100 + 12'(ni), 19'h0);
        else        s_nack_tvalid = 1'b0;
      end else begin
        s_cmpl_tvalid = 1'b0;
      end
      pulse_done();
    end
    check_val("t4_credit4", credit_o, 13'd4);
`ifdef ARB_STATS_EN
    check_val("t4_nack_grants", nack_grants_o, 16'd6);
    check_val("t4_cmpl_grants", cmpl_grants_o, 16'd1);
`else
    check_val("t4_nack_grants", nack_grants_o, 16'd0);
    check_val("t4_cmpl_grants", cmpl_grants_o, 16'd0);
`endif

    // 5: zero-length partial nack is dropped
    do_reset();
    s_nack_tdata  = nack_in(1'b0, 11'd0, 12'h055, 19'h00200);
    s_nack_tvalid = 1'b1;
    #1;
    check_val("t5_drop_tready", s_nack_tready, 1'b1);
    step();
    s_nack_tvalid = 1'b0;
    #1;
    check_val("t5_tready_off", s_nack_tready, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_req_tvalid || busy_o) seen = 1'b1;
    end
    check_val("t5_no_req", seen, 1'b0);
`ifdef ARB_STATS_EN
    check_val("t5_drop_count", drop_count_o, 8'd1);
`else
    check_val("t5_drop_count", drop_count_o, 8'd0);
`endif

    // 6: reset in WAIT_DONE, simultaneous allow+grant, overflow
    do_reset();
    give_credit(8);
    s_cmpl_tdata  = 16'h0011;
    s_cmpl_tvalid = 1'b1;
    m_req_tready  = 1'b1;
    wait_tvalid("t6_wait", 5);
    step();
    s_cmpl_tvalid = 1'b0;
    m_req_tready  = 1'b0;
    check_val("t6_busy", busy_o, 1'b1);
    check_val("t6_credit7", credit_o, 13'd7);
    aresetn = 1'b0;
    step();
    check_val("t6_rst_tvalid", m_req_tvalid, 1'b0);
    check_val("t6_rst_busy", busy_o, 1'b0);
    check_val("t6_rst_credit", credit_o, '0);
    aresetn = 1'b1;
    give_credit(2);
    s_cmpl_tdata  = 16'h0022;
    s_cmpl_tvalid = 1'b1;
    wait_tvalid("t6_wait2", 5);
    m_req_tready = 1'b1;
    allow_i      = 1'b1;
    #1;
    check_val("t6_cmpl_tready", s_cmpl_tready, 1'b1);
    step();
    allow_i       = 1'b0;
    m_req_tready  = 1'b0;
    s_cmpl_tvalid = 1'b0;
    check_val("t6_credit_same", credit_o, 13'd2);
    pulse_done();
    give_credit(8189);
    check_val("t6_credit_max", credit_o, 13'h1FFF);
    check_val("t6_no_overflow_yet", overflow_o, 1'b0);
    give_credit(1);
    check_val("t6_overflow", overflow_o, 1'b1);
    check_val("t6_credit_held", credit_o, 13'h1FFF);
    repeat (3) step();
    check_val("t6_overflow_sticky", overflow_o, 1'b1);
    do_reset();
    check_val("t6_overflow_rst", overflow_o, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
